path_tracer: RTL

PATH_TRACER -- requirements
Module: path_tracer

---
 rtl/path_tracer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/path_tracer.sv
`timescale 1ns/1ps

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 64
`endif
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE '1
`endif

// path_tracer: walks the prev table left by DijkstraTop from destination back
// to source and streams each visited node, destination first.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start; inputs latched on start
// S_EMIT    | presenting cur on node_data until node_ready
// S_RD_REQ  | first cycle of prev[cur] read, bus driven
// S_RD_WAIT | holding the read until mem_read_ready
// S_FINISH  | one-cycle done pulse, error/path_length then held
module path_tracer #(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source,
  input  logic [INDEX_WIDTH-1:0] destination,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] base_address,
  output logic                   mem_read_enable,
  input  logic                   mem_read_ready,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic                   node_valid,
  input  logic                   node_ready,
  output logic [INDEX_WIDTH-1:0] node_data,
  output logic                   node_last,
  output logic [INDEX_WIDTH-1:0] path_length,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_FINISH
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LP_NO_PREV    = `NO_PREVIOUS_NODE;
  localparam logic [31:0]            LP_MAX_NODES  = MAX_NODES;
  localparam logic [MADDR_WIDTH-1:0] LP_WORD_BYTES = MADDR_WIDTH'(MADDR_WIDTH / 8);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_cur;
  logic [INDEX_WIDTH-1:0] r_src;
  logic [INDEX_WIDTH-1:0] r_n;
  logic [INDEX_WIDTH-1:0] r_len;
  logic [MADDR_WIDTH-1:0] r_base;
  logic                   r_error;

  logic                   w_set_error;
  logic                   w_cfg_bad;
  logic                   w_last;
  logic [INDEX_WIDTH-1:0] w_len_inc;
  logic [INDEX_WIDTH-1:0] w_rd_idx;
  logic                   w_rd_bad;
  logic                   w_rd_active;
  logic [MADDR_WIDTH-1:0] w_addr;
  logic                   w_unused_data;

  // Only the low INDEX_WIDTH bits of a prev entry carry the node index.
  assign w_unused_data = ^mem_read_data;
  assign w_rd_idx      = mem_read_data[INDEX_WIDTH-1:0];
  assign w_rd_bad      = (w_rd_idx == LP_NO_PREV) || (w_rd_idx >= r_n);

  // A graph larger than the block was built for is rejected like a bad endpoint.
  assign w_cfg_bad = (source >= number_of_nodes) || (destination >= number_of_nodes) ||
                     (32'(number_of_nodes) > LP_MAX_NODES);

  assign w_last    = (r_cur == r_src);
  assign w_len_inc = r_len + 1'b1;

  // prev[j] lives after the N*N distance matrix; wraps silently at MADDR_WIDTH.
  assign w_addr = r_base +
                  (MADDR_WIDTH'(r_n) * MADDR_WIDTH'(r_n) + MADDR_WIDTH'(r_cur)) * LP_WORD_BYTES;

  assign w_rd_active     = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
  assign mem_read_enable = w_rd_active ? 1'b1 : 1'bz;
  assign mem_addr        = w_rd_active ? w_addr : {MADDR_WIDTH{1'bz}};

  assign node_valid  = (r_state == S_EMIT);
  assign node_data   = r_cur;
  assign node_last   = w_last;
  assign path_length = r_len;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);
  assign error       = r_error;

  // Next-state decode; w_set_error flags every transition into an error finish.
  always_comb begin
    w_state_nxt = r_state;
    w_set_error = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_bad) begin
            w_state_nxt = S_FINISH;
            w_set_error = 1'b1;
          end else begin
            w_state_nxt = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (node_ready) begin
          if (w_last) begin
            w_state_nxt = S_FINISH;
          end else if (w_len_inc == r_n) begin
            w_state_nxt = S_FINISH;
            w_set_error = 1'b1;
          end else begin
            w_state_nxt = S_RD_REQ;
          end
        end
      end
      S_RD_REQ, S_RD_WAIT: begin
        if (mem_read_ready) begin
          if (w_rd_bad) begin
            w_state_nxt = S_FINISH;
            w_set_error = 1'b1;
          end else begin
            w_state_nxt = S_EMIT;
          end
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus the latched trace context, length counter and error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_src   <= '0;
      r_n     <= '0;
      r_len   <= '0;
      r_base  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src   <= source;
            r_n     <= number_of_nodes;
            r_base  <= base_address;
            r_cur   <= destination;
            r_len   <= '0;
            r_error <= w_set_error;
          end
        end
        S_EMIT: begin
          if (node_ready) r_len <= w_len_inc;
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (mem_read_ready && !w_rd_bad) r_cur <= w_rd_idx;
        end
        default: ;
      endcase
      if ((r_state != S_IDLE) && w_set_error) r_error <= 1'b1;
    end
  end

endmodule
